// File: rtl/mat_mean_acc.sv
// mat_mean_acc: elementwise mean of 2^LOG2_N streamed 4x4 Q13 matrices (row-major, one element per beat).
// Latency: first mean valid the cycle after the final input accept; one beat per cycle in both phases.
// Backpressure: in_valid gaps stall accumulation; out_ready low holds out_data/out_idx stable.
// Ports: clk_mean, rst_mean (sync, active-high); en_mean start pulse (IDLE only);
//   in_valid/in_ready/in_data input stream; out_valid/out_ready/out_data/out_idx mean stream;
//   busy (ACC or OUT); done (one-cycle pulse after the last mean is accepted).
// Option: define MAT_MEAN_ACC_ROUND_EN for round-half-up means instead of floor.
module mat_mean_acc #(
  parameter  int DW     = 26,
  parameter  int LOG2_N = 4,
  localparam int AW     = DW + LOG2_N
) (
  input  logic                 clk_mean,
  input  logic                 rst_mean,
  input  logic                 en_mean,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [DW-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [DW-1:0] out_data,
  output logic [3:0]           out_idx,
  output logic                 busy,
  output logic                 done
);

  typedef enum logic [1:0] {S_IDLE, S_ACC, S_OUT} state_t;

  localparam logic [LOG2_N-1:0] SMP_LAST = '1;

`ifdef MAT_MEAN_ACC_ROUND_EN
  localparam logic signed [AW-1:0] RND = {{(AW-1){1'b0}}, 1'b1} << (LOG2_N - 1);
`endif

  state_t                state_q, state_d;
  logic signed [AW-1:0]  acc_q [16];
  logic signed [AW-1:0]  acc_d [16];
  logic [3:0]            elem_q, elem_d;
  logic [LOG2_N-1:0]     sample_q, sample_d;
  logic [3:0]            out_idx_q, out_idx_d;
  logic signed [DW-1:0]  out_data_d, out_data_q;
  logic                  done_q, done_d;
  logic signed [AW-1:0]  in_ext;

  assign in_ext = {{LOG2_N{in_data[DW-1]}}, in_data};

  // The accumulator cannot exceed N*2^(DW-1) in magnitude, so the shifted
  // value always fits DW bits and the truncation below is lossless.
  function automatic logic signed [DW-1:0] mean_of(input logic signed [AW-1:0] a);
`ifdef MAT_MEAN_ACC_ROUND_EN
    logic signed [AW-1:0] s;
    s = a + RND;
    return DW'(s >>> LOG2_N);
`else
    return DW'(a >>> LOG2_N);
`endif
  endfunction

  always_comb begin
    state_d    = state_q;
    elem_d     = elem_q;
    sample_d   = sample_q;
    out_idx_d  = out_idx_q;
    out_data_d = out_data_q;
    done_d     = 1'b0;
    for (int i = 0; i < 16; i++) acc_d[i] = acc_q[i];

    case (state_q)
      S_IDLE: begin
        if (en_mean) begin
          for (int i = 0; i < 16; i++) acc_d[i] = '0;
          elem_d    = '0;
          sample_d  = '0;
          out_idx_d = '0;
          state_d   = S_ACC;
        end
      end
      S_ACC: begin
        if (in_valid) begin
          acc_d[elem_q] = acc_q[elem_q] + in_ext;
          elem_d        = elem_q + 4'd1;
          if (elem_q == 4'd15) begin
            sample_d = sample_q + 1'b1;
            if (sample_q == SMP_LAST) begin
              // Element 0 is already final here: only element 15 is still
              // being summed on this edge.
              state_d    = S_OUT;
              out_idx_d  = '0;
              out_data_d = mean_of(acc_q[0]);
            end
          end
        end
      end
      S_OUT: begin
        if (out_ready) begin
          if (out_idx_q == 4'd15) begin
            state_d    = S_IDLE;
            out_idx_d  = '0;
            out_data_d = '0;
            done_d     = 1'b1;
          end else begin
            out_idx_d  = out_idx_q + 4'd1;
            out_data_d = mean_of(acc_q[out_idx_q + 4'd1]);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_mean) begin
    if (rst_mean) begin
      state_q    <= S_IDLE;
      elem_q     <= '0;
      sample_q   <= '0;
      out_idx_q  <= '0;
      out_data_q <= '0;
      done_q     <= 1'b0;
      for (int i = 0; i < 16; i++) acc_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      elem_q     <= elem_d;
      sample_q   <= sample_d;
      out_idx_q  <= out_idx_d;
      out_data_q <= out_data_d;
      done_q     <= done_d;
      acc_q      <= acc_d;
    end
  end

  assign in_ready  = (state_q == S_ACC);
  assign out_valid = (state_q == S_OUT);
  assign busy      = (state_q != S_IDLE);
  assign out_data  = out_data_q;
  assign out_idx   = out_idx_q;
  assign done      = done_q;

endmodule

// File: tb/tb_mat_mean_acc.sv
module tb_mat_mean_acc;

  localparam int DW     = 26;
  localparam int LOG2_N = 4;
  localparam int N      = 1 << LOG2_N;

  logic                 clk_mean = 1'b0;
  logic                 rst_mean;
  logic                 en_mean;
  logic                 in_valid;
  logic                 in_ready;
  logic signed [DW-1:0] in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [DW-1:0] out_data;
  logic [3:0]           out_idx;
  logic                 busy;
  logic                 done;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference stimulus: smp[sample][element]
  int smp [N][16];

  mat_mean_acc #(.DW(DW), .LOG2_N(LOG2_N)) dut (
    .clk_mean (clk_mean),
    .rst_mean (rst_mean),
    .en_mean  (en_mean),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_idx  (out_idx),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk_mean = ~clk_mean;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Mathematical floor of a/N, independent of how the hardware shifts.
  function automatic longint floor_div(input longint a);
    longint q;
    q = a / N;
    if ((a % N) != 0 && a < 0) q = q - 1;
    return q;
  endfunction

  function automatic int exp_mean(input int e);
    longint s;
    s = 0;
    for (int k = 0; k < N; k++) s += smp[k][e];
`ifdef MAT_MEAN_ACC_ROUND_EN
    s += N / 2;
`endif
    return int'(floor_div(s));
  endfunction

  task automatic fill(input int kind);
    logic signed [DW-1:0] r;
    for (int k = 0; k < N; k++) begin
      for (int e = 0; e < 16; e++) begin
        r = DW'($urandom);
        case (kind)
          0:       smp[k][e] = 8192;
          1:       smp[k][e] = (e == 0) ? ((k == 0) ? -1 : 0) : -3;
          2:       smp[k][e] = 33554431;
          3:       smp[k][e] = -33554432;
          default: smp[k][e] = int'(r);
        endcase
      end
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check_eq({tag, "_in_ready"},  int'(in_ready),  0);
    check_eq({tag, "_out_valid"}, int'(out_valid), 0);
    check_eq({tag, "_out_data"},  int'(out_data),  0);
    check_eq({tag, "_out_idx"},   int'(out_idx),   0);
    check_eq({tag, "_busy"},      int'(busy),      0);
    check_eq({tag, "_done"},      int'(done),      0);
  endtask

  // Start pulse with in_valid high: that beat must not be taken.
  task automatic start_run();
    @(negedge clk_mean);
    en_mean  = 1'b1;
    in_valid = 1'b1;
    in_data  = DW'(12345);
    check_eq("idle_in_ready", int'(in_ready), 0);
    @(negedge clk_mean);
    en_mean  = 1'b0;
    in_valid = 1'b0;
    check_eq("acc_busy", int'(busy), 1);
    check_eq("acc_in_ready", int'(in_ready), 1);
  endtask

  task automatic feed(input int gap_pct, input int limit, input bit en_noise);
    int k;
    int cyc;
    k   = 0;
    cyc = 0;
    while (k < limit && cyc < 4000) begin
      @(negedge clk_mean);
      cyc++;
      en_mean = en_noise && ($urandom_range(0, 9) == 0);
      if (int'($urandom_range(0, 99)) < gap_pct) begin
        in_valid = 1'b0;
        in_data  = DW'($urandom);
      end else begin
        in_valid = 1'b1;
        in_data  = DW'(smp[k / 16][k % 16]);
      end
      if (in_valid && in_ready) k++;
    end
    if (k < limit) check_eq("feed_timeout", k, limit);
  endtask

  task automatic collect(input string tag, input bit stall5, input bit en_noise);
    int got;
    int cyc;
    int stall;
    got   = 0;
    cyc   = 0;
    stall = 0;
    @(negedge clk_mean);
    in_valid = 1'b0;
    en_mean  = 1'b0;
    check_eq({tag, "_first_out_valid"}, int'(out_valid), 1);
    check_eq({tag, "_in_ready_low"}, int'(in_ready), 0);
    while (got < 16 && cyc < 200) begin
      en_mean = en_noise && ($urandom_range(0, 3) == 0);
      if (stall5 && out_valid && got == 5 && stall < 3) begin
        out_ready = 1'b0;
        check_eq({tag, "_stall_idx"},  int'(out_idx),  5);
        check_eq({tag, "_stall_data"}, int'(out_data), exp_mean(5));
        stall++;
      end else begin
        out_ready = 1'b1;
      end
      if (out_valid && out_ready) begin
        check_eq({tag, "_idx"},  int'(out_idx),  got);
        check_eq({tag, "_data"}, int'(out_data), exp_mean(got));
        got++;
      end
      @(negedge clk_mean);
      cyc++;
    end
    out_ready = 1'b0;
    en_mean   = 1'b0;
    check_eq({tag, "_beats"}, got, 16);
    if (stall5) check_eq({tag, "_stall_cycles"}, stall, 3);
    check_eq({tag, "_done_pulse"}, int'(done), 1);
    check_eq({tag, "_busy_after"}, int'(busy), 0);
    check_eq({tag, "_out_valid_after"}, int'(out_valid), 0);
    check_eq({tag, "_out_idx_after"}, int'(out_idx), 0);
    @(negedge clk_mean);
    check_eq({tag, "_done_single"}, int'(done), 0);
  endtask

  task automatic full_run(input string tag, input int kind, input int gap_pct,
                          input bit stall5, input bit en_noise);
    if (kind >= 0) fill(kind);
    start_run();
    feed(gap_pct, 16 * N, en_noise);
    collect(tag, stall5, en_noise);
  endtask

  initial begin
    rst_mean  = 1'b1;
    en_mean   = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk_mean);
    check_zero_outputs("reset");
    rst_mean = 1'b0;

    full_run("const", 0, 0, 1'b0, 1'b0);
    full_run("floor", 1, 0, 1'b0, 1'b0);
    full_run("max",   2, 0, 1'b0, 1'b0);
    full_run("min",   3, 0, 1'b0, 1'b0);
    full_run("rnd_gap",    4, 50, 1'b0, 1'b0);
    full_run("rnd_nogap", -1, 0,  1'b0, 1'b0);
    full_run("rnd_stall",  4, 20, 1'b1, 1'b1);

    // Abort a run after 7 accepted beats.
    fill(4);
    start_run();
    feed(0, 7, 1'b0);
    @(negedge clk_mean);
    in_valid = 1'b0;
    rst_mean = 1'b1;
    @(negedge clk_mean);
    check_zero_outputs("midrst");
    rst_mean = 1'b0;
    full_run("post_rst", 4, 30, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
